// File: rtl/mac_pkg.sv
// Shared widths and arithmetic helpers for the multi-lane MAC datapath.
// Saturation and rounding work on a 64-bit carrier; callers truncate to their own width.
package mac_pkg;

    localparam int DEF_LANES      = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int PROD_WIDTH     = 2 * DEF_DATA_WIDTH;
    localparam int TREE_WIDTH     = PROD_WIDTH + $clog2(DEF_LANES);

    function automatic int prod_width(input int data_width);
        return 2 * data_width;
    endfunction

    function automatic int tree_width(input int data_width, input int lanes);
        return 2 * data_width + $clog2(lanes);
    endfunction

    function automatic logic signed [63:0] sat_to(input logic signed [63:0] x, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Arithmetic right shift with round-half-up.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int sh);
        logic signed [63:0] t;
        t = x;
        if (sh > 0) begin
            t = t + (64'sd1 <<< (sh - 1));
        end
        return t >>> sh;
    endfunction

endpackage

// File: rtl/mac_adder_tree.sv
// Combinational pairwise reduction of N signed inputs; every node carries the
// full output width so the sum is exact.
module mac_adder_tree
    import mac_pkg::*;
#(
    parameter int N     = DEF_LANES,
    parameter int IN_W  = PROD_WIDTH,
    parameter int OUT_W = TREE_WIDTH
) (
    input  logic [N*IN_W-1:0] in_vec,
    output logic [OUT_W-1:0]  sum
);

    localparam int LVLS = $clog2(N);

    for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
        logic signed [OUT_W-1:0] v [N >> l];
        for (genvar j = 0; j < (N >> l); j++) begin : g_n
            if (l == 0) begin : g_leaf
                assign v[j] = OUT_W'($signed(in_vec[j*IN_W +: IN_W]));
            end else begin : g_add
                assign v[j] = g_lvl[l-1].v[2*j] + g_lvl[l-1].v[2*j+1];
            end
        end
    end

    assign sum = g_lvl[LVLS].v[0];

endmodule

// File: rtl/mac_array.sv
// Multi-lane signed MAC: multiply, registered adder tree, saturating accumulate,
// requantise, and a single-entry output register behind a valid/ready handshake.
module mac_array
    import mac_pkg::*;
#(
    parameter int LANES       = DEF_LANES,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH   = 32,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] a_vec,
    input  logic [LANES*DATA_WIDTH-1:0] b_vec,
    input  logic                        first,
    input  logic                        last,
    input  logic [SHIFT_WIDTH-1:0]      shift,
    input  logic                        relu_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        acc_out,
    output logic [DATA_WIDTH-1:0]       q_out,
    output logic                        sat
);

    localparam int PW = prod_width(DATA_WIDTH);
    localparam int TW = tree_width(DATA_WIDTH, LANES);

    logic stall;
    logic advance;

    logic                        vld_p1_q, vld_p1_d, first_p1_q, first_p1_d, last_p1_q, last_p1_d;
    logic [LANES*PW-1:0]         prod_p1_q, prod_p1_d;
    logic                        vld_p2_q, vld_p2_d, first_p2_q, first_p2_d, last_p2_q, last_p2_d;
    logic signed [TW-1:0]        sum_p2_q, sum_p2_d;
    logic [TW-1:0]               tree_sum;

    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic                         sat_acc_q, sat_acc_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
    logic signed [DATA_WIDTH-1:0] q_out_q, q_out_d;
    logic                         sat_q, sat_d;

    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [63:0]          wide;
    logic signed [63:0]          acc_next_w;
    logic signed [63:0]          r_w;
    logic signed [63:0]          q_w;
    logic                        clamp;

    // The whole pipeline freezes only while a finished result waits for its consumer.
    assign stall    = out_valid_q && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;

    // S1: lane products
    always_comb begin
        logic signed [PW-1:0] ax;
        logic signed [PW-1:0] bx;
        ax         = '0;
        bx         = '0;
        vld_p1_d   = vld_p1_q;
        first_p1_d = first_p1_q;
        last_p1_d  = last_p1_q;
        prod_p1_d  = prod_p1_q;
        if (advance) begin
            vld_p1_d   = in_valid;
            first_p1_d = first;
            last_p1_d  = last;
            for (int i = 0; i < LANES; i++) begin
                ax = PW'($signed(a_vec[i*DATA_WIDTH +: DATA_WIDTH]));
                bx = PW'($signed(b_vec[i*DATA_WIDTH +: DATA_WIDTH]));
                prod_p1_d[i*PW +: PW] = ax * bx;
            end
        end
    end

    // S2: adder tree
    mac_adder_tree #(
        .N    (LANES),
        .IN_W (PW),
        .OUT_W(TW)
    ) u_tree (
        .in_vec(prod_p1_q),
        .sum   (tree_sum)
    );

    always_comb begin
        vld_p2_d   = vld_p2_q;
        first_p2_d = first_p2_q;
        last_p2_d  = last_p2_q;
        sum_p2_d   = sum_p2_q;
        if (advance) begin
            vld_p2_d   = vld_p1_q;
            first_p2_d = first_p1_q;
            last_p2_d  = last_p1_q;
            sum_p2_d   = $signed(tree_sum);
        end
    end

    // S3: accumulate, requantise, load output register
    always_comb begin
        base       = first_p2_q ? '0 : acc_q;
        wide       = 64'(base) + 64'(sum_p2_q);
        acc_next_w = sat_to(wide, ACC_WIDTH);
        clamp      = (acc_next_w != wide);
        acc_next   = ACC_WIDTH'(acc_next_w);
        r_w        = (relu_en && acc_next < 0) ? 64'sd0 : 64'(acc_next);
        q_w        = sat_to(round_shift(r_w, int'(shift)), DATA_WIDTH);

        acc_d       = acc_q;
        sat_acc_d   = sat_acc_q;
        out_valid_d = out_valid_q;
        acc_out_d   = acc_out_q;
        q_out_d     = q_out_q;
        sat_d       = sat_q;
        if (advance) begin
            out_valid_d = 1'b0;
            if (vld_p2_q) begin
                acc_d     = acc_next;
                sat_acc_d = first_p2_q ? clamp : (sat_acc_q | clamp);
                if (last_p2_q) begin
                    out_valid_d = 1'b1;
                    acc_out_d   = acc_next;
                    q_out_d     = DATA_WIDTH'(q_w);
                    sat_d       = sat_acc_d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q    <= 1'b0;
            first_p1_q  <= 1'b0;
            last_p1_q   <= 1'b0;
            vld_p2_q    <= 1'b0;
            first_p2_q  <= 1'b0;
            last_p2_q   <= 1'b0;
            acc_q       <= '0;
            sat_acc_q   <= 1'b0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            q_out_q     <= '0;
            sat_q       <= 1'b0;
        end else begin
            vld_p1_q    <= vld_p1_d;
            first_p1_q  <= first_p1_d;
            last_p1_q   <= last_p1_d;
            vld_p2_q    <= vld_p2_d;
            first_p2_q  <= first_p2_d;
            last_p2_q   <= last_p2_d;
            acc_q       <= acc_d;
            sat_acc_q   <= sat_acc_d;
            out_valid_q <= out_valid_d;
            acc_out_q   <= acc_out_d;
            q_out_q     <= q_out_d;
            sat_q       <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        prod_p1_q <= prod_p1_d;
        sum_p2_q  <= sum_p2_d;
    end

    assign out_valid = out_valid_q;
    assign acc_out   = acc_out_q;
    assign q_out     = q_out_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_mac_array.sv
// Scoreboard bench for mac_array: a 32-bit and a 20-bit accumulator instance share
// stimulus; a behavioural model queues expected results checked at each handshake.
module tb_mac_array;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, first, last, relu_en, out_ready;
    logic [31:0] a_vec, b_vec;
    logic [4:0]  shift;
    logic        in_ready, out_valid, sat;
    logic [31:0] acc_out;
    logic [7:0]  q_out;
    logic        in_ready20, out_valid20, sat20;
    logic [19:0] acc_out20;
    logic [7:0]  q_out20;

    mac_array #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .SHIFT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_vec(a_vec), .b_vec(b_vec), .first(first), .last(last),
        .shift(shift), .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .q_out(q_out), .sat(sat)
    );

    mac_array #(.LANES(4), .DATA_WIDTH(8), .ACC_WIDTH(20), .SHIFT_WIDTH(5)) dut20 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready20),
        .a_vec(a_vec), .b_vec(b_vec), .first(first), .last(last),
        .shift(shift), .relu_en(relu_en), .out_valid(out_valid20), .out_ready(out_ready),
        .acc_out(acc_out20), .q_out(q_out20), .sat(sat20)
    );

    typedef struct {
        longint acc32;
        longint q32;
        bit     sat32;
        longint acc20;
        longint q20;
        bit     sat20;
    } exp_t;

    exp_t   sb[$];
    longint res_cyc[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    longint cyc     = 0;
    longint accept_cyc;
    longint m_acc32, m_acc20;
    bit     m_sat32, m_sat20;
    longint last_acc32, last_q32, last_acc20, last_q20;
    bit     last_sat32, last_sat20;
    bit     rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic longint clampw(input longint x, input int w, output bit c);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        c = 1'b0;
        if (x > hi) begin c = 1'b1; return hi; end
        if (x < lo) begin c = 1'b1; return lo; end
        return x;
    endfunction

    function automatic longint requant(input longint v);
        longint r;
        bit c;
        r = (relu_en && v < 0) ? 0 : v;
        if (shift != 0) r = (r + (longint'(1) <<< (shift - 1))) >>> shift;
        return clampw(r, 8, c);
    endfunction

    function automatic vector_sum_dummy_guard(); endfunction

    function automatic void model_beat(input logic [31:0] av, input logic [31:0] bv, input bit f, input bit l);
        longint s = 0;
        bit c32, c20;
        exp_t e;
        for (int i = 0; i < 4; i++)
            s += longint'($signed(av[i*8 +: 8])) * longint'($signed(bv[i*8 +: 8]));
        m_acc32 = clampw((f ? 0 : m_acc32) + s, 32, c32);
        m_acc20 = clampw((f ? 0 : m_acc20) + s, 20, c20);
        m_sat32 = f ? c32 : (m_sat32 | c32);
        m_sat20 = f ? c20 : (m_sat20 | c20);
        if (l) begin
            e.acc32 = m_acc32; e.q32 = requant(m_acc32); e.sat32 = m_sat32;
            e.acc20 = m_acc20; e.q20 = requant(m_acc20); e.sat20 = m_sat20;
            sb.push_back(e);
        end
    endfunction

    function automatic void model_reset();
        m_acc32 = 0; m_acc20 = 0; m_sat32 = 0; m_sat20 = 0;
        sb.delete();
    endfunction

    function automatic logic [31:0] vec4(input int e0, input int e1, input int e2, input int e3);
        return {8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    // Scoreboard: compare every delivered result against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            res_cyc.push_back(cyc);
            last_acc32 = longint'($signed(acc_out));
            last_q32   = longint'($signed(q_out));
            last_sat32 = sat;
            last_acc20 = longint'($signed(acc_out20));
            last_q20   = longint'($signed(q_out20));
            last_sat20 = sat20;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result acc_out=%0d with nothing outstanding", last_acc32);
            end else begin
                e = sb.pop_front();
                if (last_acc32 !== e.acc32) begin n_fail++; $display("FAIL sb_acc32 got %0d want %0d", last_acc32, e.acc32); end
                n_tests++;
                if (last_q32 !== e.q32) begin n_fail++; $display("FAIL sb_q32 got %0d want %0d", last_q32, e.q32); end
                n_tests++;
                if (last_sat32 !== e.sat32) begin n_fail++; $display("FAIL sb_sat32 got %0d want %0d", last_sat32, e.sat32); end
                n_tests++;
                if (last_acc20 !== e.acc20) begin n_fail++; $display("FAIL sb_acc20 got %0d want %0d", last_acc20, e.acc20); end
                n_tests++;
                if (last_q20 !== e.q20) begin n_fail++; $display("FAIL sb_q20 got %0d want %0d", last_q20, e.q20); end
                n_tests++;
                if (last_sat20 !== e.sat20) begin n_fail++; $display("FAIL sb_sat20 got %0d want %0d", last_sat20, e.sat20); end
            end
        end
    end

    task automatic send_beat(input logic [31:0] av, input logic [31:0] bv, input bit f, input bit l);
        int g = 0;
        a_vec = av; b_vec = bv; first = f; last = l; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && g < 100) begin @(negedge clk); g++; end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL beat_accept in_ready=%b after %0d cycles, want 1", in_ready, g);
        end else begin
            accept_cyc = cyc;
            model_beat(av, bv, f, l);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 300) begin @(negedge clk); g++; end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d, want 0", sb.size());
            sb.delete();
        end
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; first = 1'b0; last = 1'b0;
        a_vec = '0; b_vec = '0; shift = '0; relu_en = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (acc_out !== 32'd0) begin n_fail++; $display("FAIL reset_acc_out got %0d want 0", acc_out); end
        n_tests++; if (q_out !== 8'd0) begin n_fail++; $display("FAIL reset_q_out got %0d want 0", q_out); end
        n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %b want 0", sat); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_one_beat();
        longint acc_at;
        shift = 5'd0; relu_en = 1'b0; out_ready = 1'b1;
        res_cyc.delete();
        send_beat(vec4(1, 2, 3, 4), vec4(5, 6, 7, 8), 1'b1, 1'b1);
        acc_at = accept_cyc;
        drain();
        n_tests++; if (last_acc32 !== 70) begin n_fail++; $display("FAIL one_beat_acc got %0d want 70", last_acc32); end
        n_tests++; if (last_q32 !== 70) begin n_fail++; $display("FAIL one_beat_q got %0d want 70", last_q32); end
        n_tests++; if (last_sat32 !== 1'b0) begin n_fail++; $display("FAIL one_beat_sat got %b want 0", last_sat32); end
        n_tests++;
        if (res_cyc.size() != 1 || res_cyc[0] - acc_at != 3) begin
            n_fail++;
            $display("FAIL one_beat_latency got %0d results, latency %0d want 1 result, latency 3",
                     res_cyc.size(), (res_cyc.size() > 0) ? res_cyc[0] - acc_at : -1);
        end
    endtask

    task automatic test_three_beat();
        shift = 5'd3; relu_en = 1'b0; out_ready = 1'b1;
        send_beat(vec4(1, 1, 1, 1), vec4(10, 10, 10, 10), 1'b1, 1'b0);
        send_beat(vec4(1, 1, 1, 1), vec4(10, 10, 10, 10), 1'b0, 1'b0);
        send_beat(vec4(1, 1, 1, 1), vec4(10, 10, 10, 10), 1'b0, 1'b1);
        drain();
        n_tests++; if (last_acc32 !== 120) begin n_fail++; $display("FAIL three_beat_acc got %0d want 120", last_acc32); end
        n_tests++; if (last_q32 !== 15) begin n_fail++; $display("FAIL three_beat_q got %0d want 15", last_q32); end
        relu_en = 1'b1;
        send_beat(vec4(1, 1, 1, 1), vec4(-10, -10, -10, -10), 1'b1, 1'b0);
        idle(2);
        send_beat(vec4(1, 1, 1, 1), vec4(-10, -10, -10, -10), 1'b0, 1'b0);
        idle(1);
        send_beat(vec4(1, 1, 1, 1), vec4(-10, -10, -10, -10), 1'b0, 1'b1);
        drain();
        n_tests++; if (last_acc32 !== -120) begin n_fail++; $display("FAIL relu_acc got %0d want -120", last_acc32); end
        n_tests++; if (last_q32 !== 0) begin n_fail++; $display("FAIL relu_q got %0d want 0", last_q32); end
        relu_en = 1'b0;
    endtask

    task automatic test_saturation();
        shift = 5'd0; relu_en = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            send_beat(vec4(-128, -128, -128, -128), vec4(-128, -128, -128, -128), i == 0, i == 7);
        drain();
        n_tests++; if (last_acc20 !== 524287) begin n_fail++; $display("FAIL sat20_acc got %0d want 524287", last_acc20); end
        n_tests++; if (last_sat20 !== 1'b1) begin n_fail++; $display("FAIL sat20_flag got %b want 1", last_sat20); end
        n_tests++; if (last_q20 !== 127) begin n_fail++; $display("FAIL sat20_q got %0d want 127", last_q20); end
        n_tests++; if (last_acc32 !== 524288) begin n_fail++; $display("FAIL sat32_acc got %0d want 524288", last_acc32); end
        n_tests++; if (last_sat32 !== 1'b0) begin n_fail++; $display("FAIL sat32_flag got %b want 0", last_sat32); end
        send_beat(vec4(1, 1, 1, 1), vec4(1, 1, 1, 1), 1'b1, 1'b1);
        drain();
        n_tests++; if (last_sat20 !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %b want 0", last_sat20); end
        n_tests++; if (last_acc20 !== 4) begin n_fail++; $display("FAIL sat_clear_acc got %0d want 4", last_acc20); end
    endtask

    task automatic test_rounding();
        shift = 5'd2; relu_en = 1'b0; out_ready = 1'b1;
        send_beat(vec4(1, 2, 3, 4), vec4(5, 6, 7, 8), 1'b1, 1'b1);
        drain();
        n_tests++; if (last_q32 !== 18) begin n_fail++; $display("FAIL round_pos got %0d want 18", last_q32); end
        send_beat(vec4(1, 2, 3, 4), vec4(-5, -6, -7, -8), 1'b1, 1'b1);
        drain();
        n_tests++; if (last_q32 !== -17) begin n_fail++; $display("FAIL round_neg got %0d want -17", last_q32); end
        n_tests++; if (last_acc32 !== -70) begin n_fail++; $display("FAIL round_neg_acc got %0d want -70", last_acc32); end
        shift = 5'd0;
    endtask

    task automatic test_no_first();
        shift = 5'd0; relu_en = 1'b0; out_ready = 1'b1;
        send_beat(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 1'b1, 1'b1);
        send_beat(vec4(1, 1, 1, 1), vec4(1, 1, 1, 1), 1'b0, 1'b0);
        idle(2);
        send_beat(vec4(1, 1, 1, 1), vec4(3, 3, 3, 3), 1'b0, 1'b1);
        drain();
        n_tests++; if (last_acc32 !== 24) begin n_fail++; $display("FAIL running_total got %0d want 24", last_acc32); end
    endtask

    task automatic test_back_to_back();
        shift = 5'd1; relu_en = 1'b0; out_ready = 1'b1;
        res_cyc.delete();
        for (int i = 0; i < 4; i++)
            send_beat(vec4(i + 1, -i, 3, 7), vec4(9, 2 * i, -i - 1, 5), 1'b1, 1'b1);
        drain();
        n_tests++;
        if (res_cyc.size() != 4 || res_cyc[3] - res_cyc[0] != 3) begin
            n_fail++;
            $display("FAIL back_to_back got %0d results over %0d cycles want 4 over 3", res_cyc.size(),
                     (res_cyc.size() > 0) ? res_cyc[res_cyc.size()-1] - res_cyc[0] : -1);
        end
    endtask

    task automatic test_backpressure();
        shift = 5'd0; relu_en = 1'b0; out_ready = 1'b0;
        res_cyc.delete();
        send_beat(vec4(1, 1, 1, 1), vec4(1, 1, 1, 1), 1'b1, 1'b1);
        send_beat(vec4(2, 2, 2, 2), vec4(2, 2, 2, 2), 1'b1, 1'b1);
        send_beat(vec4(3, 3, 3, 3), vec4(3, 3, 3, 3), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cycle %0d got %b want 0", i, in_ready); end
            n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid cycle %0d got %b want 1", i, out_valid); end
            n_tests++; if (acc_out !== 32'd4) begin n_fail++; $display("FAIL bp_acc_hold cycle %0d got %0d want 4", i, acc_out); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        n_tests++; if (res_cyc.size() != 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", res_cyc.size()); end
        n_tests++; if (last_acc32 !== 36) begin n_fail++; $display("FAIL bp_last got %0d want 36", last_acc32); end
    endtask

    task automatic test_reset_mid();
        shift = 5'd0; relu_en = 1'b0; out_ready = 1'b1;
        send_beat(vec4(1, 1, 1, 1), vec4(10, 10, 10, 10), 1'b1, 1'b0);
        send_beat(vec4(1, 1, 1, 1), vec4(10, 10, 10, 10), 1'b0, 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        model_reset();
        res_cyc.delete();
        send_beat(vec4(1, 1, 1, 1), vec4(2, 2, 2, 2), 1'b1, 1'b1);
        drain();
        n_tests++; if (res_cyc.size() != 1) begin n_fail++; $display("FAIL rst_mid_count got %0d want 1", res_cyc.size()); end
        n_tests++; if (last_acc32 !== 8) begin n_fail++; $display("FAIL rst_mid_acc got %0d want 8", last_acc32); end
    endtask

    task automatic test_random();
        int len;
        rand_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            shift   = 5'($urandom_range(0, 9));
            relu_en = 1'($urandom_range(0, 1));
            len     = $urandom_range(1, 4);
            for (int k = 0; k < len; k++) begin
                send_beat($urandom(), $urandom(), k == 0, k == len - 1);
                if ($urandom_range(0, 2) == 0) idle(1);
            end
            drain();
        end
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_one_beat();
        test_three_beat();
        test_saturation();
        test_rounding();
        test_no_first();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
